// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan controller.
// The optional dimming feature is selected with the SEG_SCAN_DIM_EN macro.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    ON
  } scan_state_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       blank;
  } digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // The slot counter must hold the larger of the two slot phases.
  function automatic int cnt_width(input int on_cyc, input int dead_cyc);
    return (on_cyc > dead_cyc) ? $clog2(on_cyc) : $clog2(dead_cyc);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph {g,f,e,d,c,b,a}.
module seg7_hex_decode (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with dead-time between digits.
// Define SEG_SCAN_DIM_EN to add the duty input and 16-step PWM anode dimming.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int ON_CYC   = 100000,
  parameter int DEAD_CYC = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [2:0]      wr_idx,
  input  logic [3:0]      wr_nib,
  input  logic            wr_dp,
  input  logic            wr_blank,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]      duty,
`endif
  output logic [6:0]      seg,
  output logic            dp,
  output logic [NDIG-1:0] an,
  output logic            frame_done
);

  localparam int              CNT_W     = cnt_width(ON_CYC, DEAD_CYC);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [2:0]      LAST_IDX  = 3'(NDIG - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic             fd_q, fd_d;
  logic [6:0]       glyph;
  logic [NDIG-1:0]  lit_an;
  logic [NDIG-1:0]  on_an;

  // Eight entries regardless of NDIG so a 3-bit index never leaves the array.
  digit_t file_q [8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) file_q[i] <= '{nib: 4'h0, dp: 1'b0, blank: 1'b1};
    end else if (wr_en && ({1'b0, wr_idx} < 4'(NDIG))) begin
      file_q[wr_idx] <= '{nib: wr_nib, dp: wr_dp, blank: wr_blank};
    end
  end

  seg7_hex_decode u_dec (
    .nib_i (file_q[idx_q].nib),
    .seg_o (glyph)
  );

  assign lit_an = ~(NDIG'(1) << idx_q);

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] pwm_q;
  logic [3:0] pwm_nx;

  assign pwm_nx = pwm_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_nx;
  end

  // Gate on the pwm value that will be current while the registered anode is visible.
  assign on_an = (pwm_nx <= duty) ? lit_an : '1;
`else
  assign on_an = lit_an;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    an_d    = an_q;
    fd_d    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      an_d    = '1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DEAD;
          cnt_d   = '0;
          idx_d   = 3'd0;
          seg_d   = SEG_BLANK;
          dp_d    = 1'b1;
          an_d    = '1;
        end
        DEAD: begin
          an_d = '1;
          if (cnt_q == DEAD_LAST) begin
            state_d = ON;
            cnt_d   = '0;
            seg_d   = file_q[idx_q].blank ? SEG_BLANK : glyph;
            dp_d    = file_q[idx_q].blank ? 1'b1 : ~file_q[idx_q].dp;
            an_d    = on_an;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = DEAD;
            cnt_d   = '0;
            idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
            fd_d    = (idx_q == LAST_IDX);
            seg_d   = SEG_BLANK;
            dp_d    = 1'b1;
            an_d    = '1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            an_d  = on_an;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
